// File: rtl/riot_pkg.sv
// Shared constants for the RRIOT port A/B block: register addresses, status bit positions, edge polarity.
package riot_pkg;

  localparam logic [2:0] ADDR_PA       = 3'b000;
  localparam logic [2:0] ADDR_DDRA     = 3'b001;
  localparam logic [2:0] ADDR_PB       = 3'b010;
  localparam logic [2:0] ADDR_DDRB     = 3'b011;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'b100;

  localparam int FLAG_PA7   = 7;
  localparam int FLAG_TIMER = 6;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  function automatic logic [7:0] status_byte(input logic pa7_flag, input logic timer_active);
    status_byte             = 8'h00;
    status_byte[FLAG_PA7]   = pa7_flag;
    status_byte[FLAG_TIMER] = timer_active;
  endfunction

endpackage

// File: rtl/riot_sync_edge.sv
// N-bit pin synchroniser (STAGES cycles) plus MSB edge detector one cycle after that; no backpressure.
module riot_sync_edge
  import riot_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  input  logic         edge_pol_i,
  output logic [W-1:0] q_sync_o,
  output logic         edge_o
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic                     msb_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      msb_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[STAGES-2:0], d_i};
      msb_prev_q <= q_sync_o[W-1];
    end
  end

  assign q_sync_o = sync_q[STAGES-1];
  assign edge_o   = (edge_pol_i == EDGE_RISE) ? (q_sync_o[W-1] & ~msb_prev_q)
                                              : (~q_sync_o[W-1] & msb_prev_q);

endmodule

// File: rtl/riot_io_ports.sv
// RRIOT port A/B registers, PA7 edge interrupt and PB7 timer-IRQ pin; reads captured one posedge
// into a latch, irq_n registered one cycle after flag/timer; no backpressure.
module riot_io_ports
  import riot_pkg::*;
#(
  parameter bit PB7_IRQ     = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       we_n,
  input  logic [2:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       OE,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  input  logic       timer_irq_n,
  input  logic       timer_irq_en,
  output logic       irq_n
);

  logic [7:0] ora_q, ora_d, orb_q, orb_d, ddra_q, ddra_d, ddrb_q, ddrb_d, rdata_q, rdata_d;
  logic       pa7_ie_q, pa7_ie_d, edge_pol_q, edge_pol_d, pa7_flag_q, pa7_flag_d, irq_n_q, irq_n_d;
  logic [7:0] pa_sync, pb_sync;
  logic       pa7_edge, unused_pb7_edge;
  logic       rd_access, wr_access, irq_sel, timer_active, pb7_timer;

  assign rd_access    = enable & we_n;
  assign wr_access    = enable & ~we_n;
  assign irq_sel      = |(A & ADDR_IRQ_MASK);
  assign timer_active = timer_irq_en & ~timer_irq_n;

  riot_sync_edge #(.W(8), .STAGES(SYNC_STAGES)) u_sync_pa (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_i        (pa_in),
    .edge_pol_i (edge_pol_q),
    .q_sync_o   (pa_sync),
    .edge_o     (pa7_edge)
  );

  riot_sync_edge #(.W(8), .STAGES(SYNC_STAGES)) u_sync_pb (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_i        (pb_in),
    .edge_pol_i (EDGE_FALL),
    .q_sync_o   (pb_sync),
    .edge_o     (unused_pb7_edge)
  );

  always_comb begin
    ora_d      = ora_q;
    orb_d      = orb_q;
    ddra_d     = ddra_q;
    ddrb_d     = ddrb_q;
    pa7_ie_d   = pa7_ie_q;
    edge_pol_d = edge_pol_q;
    rdata_d    = rdata_q;
    if (wr_access) begin
      if (irq_sel) begin
        pa7_ie_d   = A[0];
        edge_pol_d = A[1];
      end else begin
        case (A)
          ADDR_PA:   ora_d  = DI;
          ADDR_DDRA: ddra_d = DI;
          ADDR_PB:   orb_d  = DI;
          ADDR_DDRB: ddrb_d = DI;
          default:   ;
        endcase
      end
    end
    if (rd_access) begin
      if (irq_sel) begin
        rdata_d = status_byte(pa7_flag_q, timer_active);
      end else begin
        case (A)
          ADDR_PA:   rdata_d = pa_sync;
          ADDR_DDRA: rdata_d = ddra_q;
          ADDR_PB:   rdata_d = (orb_q & ddrb_q) | (pb_sync & ~ddrb_q);
          ADDR_DDRB: rdata_d = ddrb_q;
          default:   ;
        endcase
      end
    end
    // A new edge beats a clearing status read in the same cycle.
    pa7_flag_d = pa7_edge | (pa7_flag_q & ~(rd_access & irq_sel));
    irq_n_d    = ~((pa7_flag_q & pa7_ie_q) | timer_active);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ora_q      <= 8'h00;
      orb_q      <= 8'h00;
      ddra_q     <= 8'h00;
      ddrb_q     <= 8'h00;
      rdata_q    <= 8'h00;
      pa7_ie_q   <= 1'b0;
      edge_pol_q <= EDGE_FALL;
      pa7_flag_q <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      ora_q      <= ora_d;
      orb_q      <= orb_d;
      ddra_q     <= ddra_d;
      ddrb_q     <= ddrb_d;
      rdata_q    <= rdata_d;
      pa7_ie_q   <= pa7_ie_d;
      edge_pol_q <= edge_pol_d;
      pa7_flag_q <= pa7_flag_d;
      irq_n_q    <= irq_n_d;
    end
  end

  // PB7 becomes an open-drain copy of the timer IRQ; ORB[7]/DDRB[7] are kept but not driven.
  assign pb7_timer = PB7_IRQ && timer_irq_en;
  assign pb_out    = pb7_timer ? {1'b0, orb_q[6:0]} : orb_q;
  assign pb_oe     = pb7_timer ? {~timer_irq_n, ddrb_q[6:0]} : ddrb_q;
  assign pa_out    = ora_q;
  assign pa_oe     = ddra_q;
  assign DO        = rd_access ? rdata_q : 8'h00;
  assign OE        = rd_access;
  assign irq_n     = irq_n_q;

endmodule

// File: tb/tb_riot_io_ports.sv
// Bench for riot_io_ports: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_riot_io_ports;

  localparam int SYNC = 2;
  localparam bit PB7  = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n, enable, we_n, OE, timer_irq_n, timer_irq_en, irq_n;
  logic [2:0] A;
  logic [7:0] DI, DO, pa_in, pa_out, pa_oe, pb_in, pb_out, pb_oe;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [7:0] m_ora, m_orb, m_ddra, m_ddrb, m_rd;
  logic       m_ie, m_pol, m_flag, m_prev, m_irq_n;
  logic [7:0] pa_hist [SYNC];
  logic [7:0] pb_hist [SYNC];

  always #5 clk = ~clk;

  riot_io_ports #(.PB7_IRQ(PB7), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .we_n(we_n), .A(A), .DI(DI), .DO(DO), .OE(OE),
    .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe), .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
    .timer_irq_n(timer_irq_n), .timer_irq_en(timer_irq_en), .irq_n(irq_n)
  );

  task automatic model_reset();
    m_ora = 0; m_orb = 0; m_ddra = 0; m_ddrb = 0; m_rd = 0;
    m_ie = 0; m_pol = 0; m_flag = 0; m_prev = 0; m_irq_n = 1;
    for (int i = 0; i < SYNC; i++) begin pa_hist[i] = 0; pb_hist[i] = 0; end
  endtask

  // Pins become visible SYNC edges after they are sampled; everything else follows the register rules.
  task automatic model_step();
    logic [7:0] vpa, vpb;
    logic       tact, edg, rd, wr;
    vpa  = pa_hist[SYNC-1];
    vpb  = pb_hist[SYNC-1];
    tact = timer_irq_en & ~timer_irq_n;
    rd   = enable & we_n;
    wr   = enable & ~we_n;
    edg  = m_pol ? (vpa[7] & ~m_prev) : (~vpa[7] & m_prev);
    m_irq_n = ~((m_flag & m_ie) | tact);
    if (rd) begin
      if (A >= 4) m_rd = {m_flag, tact, 6'b0};
      else if (A == 0) m_rd = vpa;
      else if (A == 1) m_rd = m_ddra;
      else if (A == 2) m_rd = (m_orb & m_ddrb) | (vpb & ~m_ddrb);
      else m_rd = m_ddrb;
    end
    m_flag = edg | (m_flag & ~(rd & A[2]));
    if (wr) begin
      if (A >= 4) begin m_ie = A[0]; m_pol = A[1]; end
      else if (A == 0) m_ora = DI;
      else if (A == 1) m_ddra = DI;
      else if (A == 2) m_orb = DI;
      else m_ddrb = DI;
    end
    m_prev = vpa[7];
    for (int i = SYNC - 1; i > 0; i--) begin pa_hist[i] = pa_hist[i-1]; pb_hist[i] = pb_hist[i-1]; end
    pa_hist[0] = pa_in;
    pb_hist[0] = pb_in;
  endtask

  task automatic tick();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    enable = 1; we_n = 0; A = a; DI = d; tick(); enable = 0; we_n = 1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    enable = 1; we_n = 1; A = a; tick(); d = DO; enable = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; we_n = 1; A = 0; DI = 0; pa_in = 0; pb_in = 0;
    timer_irq_n = 1; timer_irq_en = 0;
    model_reset();
    tick(); tick();
    checks++; if ({pa_out, pa_oe, pb_out, pb_oe} !== 32'h0) begin errors++; $display("FAIL reset_ports: got %h exp 0", {pa_out, pa_oe, pb_out, pb_oe}); end
    checks++; if ({OE, DO, irq_n} !== 10'h001) begin errors++; $display("FAIL reset_bus: got oe=%b do=%h irq_n=%b", OE, DO, irq_n); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_port_read();
    logic [7:0] d;
    pa_in = 8'hA5; pb_in = 8'h3C;
    repeat (SYNC) tick();
    rd(3'b000, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL pa_read: got %h exp a5", d); end
    rd(3'b010, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL pb_read: got %h exp 3c", d); end
    checks++; if ({pa_oe, pb_oe, irq_n} !== 17'h00001) begin errors++; $display("FAIL idle_oe: got pa_oe=%h pb_oe=%h irq_n=%b", pa_oe, pb_oe, irq_n); end
    pa_in = 8'h5A;
    repeat (SYNC - 1) tick();
    rd(3'b000, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL sync_early: got %h exp a5", d); end
    rd(3'b000, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL sync_late: got %h exp 5a", d); end
  endtask

  task automatic test_ddrb_pb();
    logic [7:0] d;
    pb_in = 8'h0F;
    wr(3'b011, 8'hF0);
    wr(3'b010, 8'h5A);
    repeat (SYNC) tick();
    checks++; if ({pb_oe, pb_out} !== 16'hF05A) begin errors++; $display("FAIL pb_drive: got oe=%h out=%h exp f0/5a", pb_oe, pb_out); end
    rd(3'b010, d);
    checks++; if (d !== 8'h5F) begin errors++; $display("FAIL pb_mixed_read: got %h exp 5f", d); end
    rd(3'b011, d);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL ddrb_read: got %h exp f0", d); end
  endtask

  task automatic test_pa7_edge();
    logic [7:0] d;
    // Earlier A5->5A was a falling edge under the reset polarity: flagged but masked.
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL masked_flag_irq: got %b exp 1", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL masked_flag_read: got %h exp 80", d); end
    wr(3'b111, 8'h00);
    pa_in = 8'hDA;
    repeat (3) tick();
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL edge_irq_early: got %b exp 1", irq_n); end
    tick();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL edge_irq_asserted: got %b exp 0", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL edge_status: got %h exp 80", d); end
    tick();
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL edge_irq_cleared: got %b exp 1", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL flag_cleared: got %h exp 00", d); end
  endtask

  task automatic test_polarity();
    logic [7:0] d;
    pa_in = 8'h5A;
    repeat (SYNC + 1) tick();
    wr(3'b101, 8'hFF);
    pa_in = 8'hDA;
    repeat (SYNC + 2) tick();
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL wrong_pol_irq: got %b exp 1", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL wrong_pol_flag: got %h exp 00", d); end
  endtask

  task automatic test_edge_vs_clear();
    logic [7:0] d;
    pa_in = 8'h5A;
    repeat (SYNC) tick();
    rd(3'b100, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL collide_capture: got %h exp 00", d); end
    rd(3'b100, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL collide_set_wins: got %h exp 80", d); end
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL collide_irq: got %b exp 0", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL collide_cleared: got %h exp 00", d); end
  endtask

  task automatic test_pb7_timer();
    logic [7:0] d;
    wr(3'b011, 8'hFF);
    wr(3'b010, 8'h80);
    timer_irq_en = 1; timer_irq_n = 0; #1;
    checks++; if ({pb_oe, pb_out} !== 16'hFF00) begin errors++; $display("FAIL pb7_timer_drive: got oe=%h out=%h exp ff/00", pb_oe, pb_out); end
    tick();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL timer_irq: got %b exp 0", irq_n); end
    rd(3'b100, d);
    checks++; if (d !== 8'h40) begin errors++; $display("FAIL timer_status: got %h exp 40", d); end
    timer_irq_n = 1; #1;
    checks++; if ({pb_oe, pb_out} !== 16'h7F00) begin errors++; $display("FAIL pb7_released: got oe=%h out=%h exp 7f/00", pb_oe, pb_out); end
    timer_irq_en = 0; #1;
    checks++; if ({pb_oe, pb_out} !== 16'hFF80) begin errors++; $display("FAIL pb7_plain: got oe=%h out=%h exp ff/80", pb_oe, pb_out); end
    tick(); tick();
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL timer_irq_idle: got %b exp 1", irq_n); end
  endtask

  task automatic test_random();
    logic [41:0] exp_v, got_v;
    logic        pbm;
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 2) == 0);
      we_n   = 1'($urandom_range(0, 1));
      A      = 3'($urandom);
      DI     = 8'($urandom);
      if ($urandom_range(0, 5) == 0) pa_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) pb_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        timer_irq_en = 1'($urandom_range(0, 1));
        timer_irq_n  = 1'($urandom_range(0, 1));
      end
      tick();
      pbm   = PB7 && timer_irq_en;
      exp_v = {((enable && we_n) ? m_rd : 8'h00), (enable && we_n), m_ora, m_ddra,
               (pbm ? {1'b0, m_orb[6:0]} : m_orb), (pbm ? {~timer_irq_n, m_ddrb[6:0]} : m_ddrb), m_irq_n};
      got_v = {DO, OE, pa_out, pa_oe, pb_out, pb_oe, irq_n};
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL random cycle %0d: got %h exp %h", i, got_v, exp_v); end
    end
    enable = 0; we_n = 1; timer_irq_en = 0; timer_irq_n = 1;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d;
    pa_in = 8'h00;
    repeat (SYNC + 1) tick();
    wr(3'b111, 8'h00);
    pa_in = 8'h80;
    repeat (SYNC + 2) tick();
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL pre_reset_irq: got %b exp 0", irq_n); end
    enable = 1; we_n = 0; A = 3'b001; DI = 8'h77;
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++; if ({pa_out, pa_oe, pb_out, pb_oe} !== 32'h0) begin errors++; $display("FAIL async_reset_ports: got %h exp 0", {pa_out, pa_oe, pb_out, pb_oe}); end
    checks++; if ({OE, DO, irq_n} !== 10'h001) begin errors++; $display("FAIL async_reset_bus: got oe=%b do=%h irq_n=%b", OE, DO, irq_n); end
    tick();
    enable = 0; we_n = 1; rst_n = 1;
    tick();
    checks++; if (pa_oe !== 8'h00) begin errors++; $display("FAIL write_discarded: got %h exp 00", pa_oe); end
    rd(3'b100, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL flag_lost: got %h exp 00", d); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL post_reset_irq: got %b exp 1", irq_n); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_port_read();
    test_ddrb_pb();
    test_pa7_edge();
    test_polarity();
    test_edge_vs_clear();
    test_pb7_timer();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riot_io_ports.md
Name: riot_io_ports

Overview:
- Port A/B I/O block for the RRIOT peripheral.
- Sits beside the interval timer on the same chip-select (`enable`), bus and address lines.
- Directly consumes the timer's `irq` / `irq_en` outputs:
  - routes the timer interrupt onto PB7 (open-drain);
  - merges it with a PA7 edge-detect interrupt into one CPU interrupt line.
- Provides data-direction registers, output registers, input synchronisers and an interrupt flag register.

Parameters:
- PB7_IRQ, 1, when 1 PB7 becomes the open-drain timer-IRQ pin whenever `timer_irq_en`=1; when 0 PB7 is plain I/O.
- SYNC_STAGES, 2, synchroniser depth on `pa_in` / `pb_in` (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  chip select for this block, decoded upstream
- we_n  in  1  1 = read, 0 = write
- A  in  3  register address
- DI  in  8  write data from CPU
- DO  out  8  read data to CPU
- OE  out  1  high while DO is driven
- pa_in  in  8  port A pin levels (asynchronous)
- pa_out  out  8  port A output register
- pa_oe  out  8  port A drive enables (= DDRA)
- pb_in  in  8  port B pin levels (asynchronous)
- pb_out  out  8  port B output values
- pb_oe  out  8  port B drive enables
- timer_irq_n  in  1  timer interrupt, active-low
- timer_irq_en  in  1  timer interrupt enable
- irq_n  out  1  combined CPU interrupt, active-low, registered

Behaviour:
- Clock and reset: single clock `clk`; reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - ORA, ORB, DDRA, DDRB = 0x00; pa_out, pb_out, pa_oe, pb_oe = 0x00.
  - pa7_flag = 0, pa7_ie = 0, edge_pol = 0 (falling).
  - Synchroniser flops and pa7_prev = 0; read latch = 0x00; irq_n = 1.
- Address map, A[2:0]:
  - 000 = PA data (write ORA).
  - 001 = DDRA.
  - 010 = PB data (write ORB).
  - 011 = DDRB.
  - 1xx write: pa7_ie <= A[0], edge_pol <= A[1]; DI is ignored.
  - 1xx read: {pa7_flag, timer_active, 6'b0}, where timer_active = timer_irq_en & ~timer_irq_n.
- Writes: on posedge when enable & ~we_n & rst_n.
- Reads, same capture style as the timer:
  - On posedge with enable & we_n, the addressed value is captured into the read latch.
  - DO/OE are combinational: OE=1 and DO=latch iff enable & we_n; otherwise OE=0 and DO=0x00.
- Read values:
  - PA read = synchronised pa_in on all 8 bits.
  - PB read = (ORB & DDRB) | (pb_sync & ~DDRB).
  - DDRA/DDRB read back their stored values.
- Synchronisers: SYNC_STAGES flops per bit. A pin change is visible to reads SYNC_STAGES posedges later.
- PA7 edge detect:
  - pa7_prev <= pa_sync[7] every cycle.
  - edge = edge_pol ? (pa_sync[7] & ~pa7_prev) : (~pa_sync[7] & pa7_prev).
  - edge sets pa7_flag.
  - A read capture at 1xx clears pa7_flag; the captured value shows the pre-clear flag.
  - Edge and clearing read in the same cycle: set wins, flag stays 1.
  - Edge detection is independent of DDRA.
  - pa7_ie only gates irq_n, never the flag.
- PB7 mux (PB7_IRQ=1 and timer_irq_en=1):
  - pb_out[7] = 0 and pb_oe[7] = ~timer_irq_n (open drain).
  - ORB[7]/DDRB[7] are retained but not driven.
- PB7 otherwise:
  - pb_out = ORB, pb_oe = DDRB.
  - pa_out = ORA and pa_oe = DDRA always.
- irq_n register:
  - irq_n <= ~((pa7_flag & pa7_ie) | timer_active), updated every posedge.
  - One cycle of latency from the flag or timer input.
- Reset mid-operation: all state returns to reset values immediately. An in-flight write is discarded, and a pending flag is lost.
- Accesses with enable=0 have no effect, including no flag clear.

Decomposition:
- Shared package `riot_pkg` holds:
  - address constants (ADDR_PA, ADDR_DDRA, ADDR_PB, ADDR_DDRB, ADDR_IRQ_MASK);
  - flag bit positions (FLAG_PA7 = 7, FLAG_TIMER = 6);
  - edge polarity encodings.
- One sub-module `riot_sync_edge`: a parameterised N-bit synchroniser plus single-bit edge detector with selectable polarity, instantiated once per port (edge output used only on port A).

Test Plan:
- Reset, then read 000 and 010 with pins 0xA5 / 0x3C -> DO = 0xA5 and 0x3C after SYNC_STAGES cycles; all oe = 0; irq_n = 1.
- Write DDRB = 0xF0, ORB = 0x5A, pins pb_in = 0x0F -> pb_oe = 0xF0; PB read = 0x5F.
- Write 1x1 with A[1]=1 (rising, ie=1), toggle pa_in[7] 0->1 -> flag set 3 cycles later; irq_n low one cycle after. Read 1xx -> DO = 0x80, flag cleared, irq_n returns to 1.
- Falling polarity with a rising pa_in[7] -> no flag. Edge arriving in the same cycle as a clearing read -> flag remains 1.
- PB7_IRQ=1, timer_irq_en=1, timer_irq_n=0, DDRB=0xFF, ORB[7]=1 -> pb_oe[7] = 1, pb_out[7] = 0, irq_n = 0, status read bit6 = 1. With timer_irq_en=0 -> pb_out[7] = 1 from ORB.
- Assert rst_n low mid-write with flag set -> all outputs at reset values asynchronously; the written register is unchanged from reset.
